// File: rtl/pkg_entrada.sv
// pkg_entrada: shared state encodings and constants for the input front-end.
package pkg_entrada;
  typedef enum logic [1:0] {
    S_A      = 2'd0,
    S_B      = 2'd1,
    S_OP     = 2'd2,
    S_MOSTRA = 2'd3
  } estado_t;
  localparam int DEBOUNCE_DEFAULT = 500000;
  localparam int SYNC_DEPTH = 2;
endpackage

// File: rtl/debounce_tecla.sv
// debounce_tecla: synchronizes, debounces and edge-detects one active-low key.
module debounce_tecla
  import pkg_entrada::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic key_ni,
  output logic press_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [SYNC_DEPTH-1:0] sync_q, rdy_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic acc_q, acc_d, armed_q, armed_d, press_q, press_d;
  logic lvl, differ, flip;
  // Arming waits until the synchronizer holds real samples and the key is seen
  // released, so a key held through reset never yields a press.
  always_comb begin
    lvl = sync_q[SYNC_DEPTH-1];
    differ = lvl != acc_q;
    flip = differ && cnt_q == CW'(DEBOUNCE_CYCLES - 1);
    cnt_d = (!differ || flip) ? '0 : cnt_q + 1'b1;
    acc_d = flip ? lvl : acc_q;
    armed_d = armed_q | (rdy_q[SYNC_DEPTH-1] & lvl & acc_q);
    press_d = armed_q & flip & ~lvl;
  end
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync_q  <= '1;
      rdy_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= 1'b1;
      armed_q <= 1'b0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_DEPTH-2:0], key_ni};
      rdy_q   <= {rdy_q[SYNC_DEPTH-2:0], 1'b1};
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      armed_q <= armed_d;
      press_q <= press_d;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/controlador_entrada.sv
// controlador_entrada: button-driven entry of ULA operands, carry-in and operation.
module controlador_entrada
  import pkg_entrada::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic       CLOCK_50,
  input  logic       RST_N,
  input  logic [9:0] SW,
  input  logic       KEY0,
  input  logic       KEY1,
  output logic [3:0] OP_A,
  output logic [3:0] OP_B,
  output logic       CIN,
  output logic [2:0] SEL,
  output logic [1:0] ESTADO,
  output logic       VALID
);
  estado_t state_q, state_d;
  logic [3:0] op_a_q, op_a_d, op_b_q, op_b_d;
  logic [2:0] sel_q, sel_d;
  logic cin_q, cin_d, press0, press1, ld, sw_unused;
  assign sw_unused = ^{SW[9], SW[7:4]};
  debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key0 (
    .clk_i(CLOCK_50), .rst_ni(RST_N), .key_ni(KEY0), .press_o(press0)
  );
  debounce_tecla #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key1 (
    .clk_i(CLOCK_50), .rst_ni(RST_N), .key_ni(KEY1), .press_o(press1)
  );
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) state_q <= S_A;
    else state_q <= state_d;
  end
  // Cancel dominates confirm when both pulses coincide.
  always_comb begin
    ld = press0 & ~press1;
    state_d = press1 ? S_A : !press0 ? state_q :
              state_q == S_MOSTRA ? S_A : estado_t'(state_q + 2'd1);
    op_a_d = (ld && state_q == S_A) ? SW[3:0] : op_a_q;
    op_b_d = (ld && state_q == S_B) ? SW[3:0] : op_b_q;
    sel_d = (ld && state_q == S_OP) ? SW[2:0] : sel_q;
    cin_d = (ld && state_q == S_OP) ? SW[8] : cin_q;
  end
  always_ff @(posedge CLOCK_50) begin
    if (!RST_N) begin
      op_a_q <= '0;
      op_b_q <= '0;
      sel_q  <= '0;
      cin_q  <= 1'b0;
    end else begin
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      sel_q  <= sel_d;
      cin_q  <= cin_d;
    end
  end
  always_comb begin
    ESTADO = state_q;
    VALID = state_q == S_MOSTRA;
    OP_A = op_a_q;
    OP_B = op_b_q;
    SEL = sel_q;
    CIN = cin_q;
  end
endmodule
